// File: rtl/rah_arb_pkg.sv
// Shared types for the RAH application write arbiter: FSM state encoding and
// the app-id width helper.
package rah_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of an app index; never narrower than one bit.
    function automatic int unsigned calc_id_width(input int unsigned n);
        if (n > 32'd1) begin
            return 32'($clog2(n));
        end
        return 32'd1;
    endfunction

endpackage

// File: rtl/rah_app_fifo.sv
// Per-channel write buffer: FIFO with registered status flags and a sticky
// overflow flag for writes dropped while full.
module rah_app_fifo #(
    parameter int unsigned DATA_WIDTH = 48,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  ovf_clr,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  one_left,
    output logic                  overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  empty_q, empty_d;
    logic                  one_left_q, one_left_d;
    logic                  overflow_q, overflow_d;
    logic                  wr_acc_c;
    logic                  rd_acc_c;

    // Acceptance is judged against the flags registered at this edge.
    assign wr_acc_c = wr_en && !full_q;
    assign rd_acc_c = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc_c && !rd_acc_c) begin
            count_d = count_q + CW'(1);
        end else if (!wr_acc_c && rd_acc_c) begin
            count_d = count_q - CW'(1);
        end
        full_d        = (count_d == CW'(DEPTH));
        almost_full_d = (count_d >= CW'(DEPTH - 1));
        empty_d       = (count_d == CW'(0));
        one_left_d    = (count_d == CW'(1));
    end

    // A set from a dropped write takes priority over a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (wr_en && full_q) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
            empty_q       <= 1'b1;
            one_left_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
            empty_q       <= empty_d;
            one_left_q    <= one_left_d;
            overflow_q    <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q];
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign empty       = empty_q;
    assign one_left    = one_left_q;
    assign overflow    = overflow_q;

endmodule

// File: rtl/rah_app_arbiter.sv
// Round-robin burst arbiter merging NUM_APPS buffered app write channels into
// one registered valid/ready stream toward the RAH encoder.
module rah_app_arbiter
    import rah_arb_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 48,
    parameter  int unsigned NUM_APPS   = 4,
    parameter  int unsigned DEPTH      = 4,
    parameter  int unsigned BURST      = 2,
    localparam int unsigned ID_WIDTH   = calc_id_width(NUM_APPS)
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_APPS-1:0]            send_data,
    input  logic [NUM_APPS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_APPS-1:0]            wr_full,
    output logic [NUM_APPS-1:0]            wr_almost_full,
    output logic [NUM_APPS-1:0]            overflow,
    input  logic [NUM_APPS-1:0]            overflow_clr,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [ID_WIDTH-1:0]            out_app_id
);

    localparam int unsigned BEAT_W = 32'($clog2(BURST + 1));

    arb_state_e            state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_app_id_q, out_app_id_d;

    logic [NUM_APPS-1:0]   fifo_empty;
    logic [NUM_APPS-1:0]   fifo_one_left;
    logic [NUM_APPS-1:0]   rd_en_c;
    logic [DATA_WIDTH-1:0] head_data [NUM_APPS];
    logic [ID_WIDTH-1:0]   rr_pick_c;
    logic                  rr_found_c;
    logic                  load_c;
    logic                  drain_c;

    for (genvar i = 0; i < NUM_APPS; i++) begin : g_chan
        rah_app_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rstn        (rstn),
            .wr_en       (send_data[i]),
            .wr_data     (wr_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .rd_en       (rd_en_c[i]),
            .rd_data     (head_data[i]),
            .ovf_clr     (overflow_clr[i]),
            .full        (wr_full[i]),
            .almost_full (wr_almost_full[i]),
            .empty       (fifo_empty[i]),
            .one_left    (fifo_one_left[i]),
            .overflow    (overflow[i])
        );

        assign rd_en_c[i] = load_c && (grant_q == ID_WIDTH'(i));
    end

    // First non-empty channel after last_grant, wrapping to channel 0.
    always_comb begin
        rr_pick_c  = last_grant_q;
        rr_found_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_APPS; k++) begin
            if (!rr_found_c &&
                !fifo_empty[ID_WIDTH'((32'(last_grant_q) + k) % NUM_APPS)]) begin
                rr_pick_c  = ID_WIDTH'((32'(last_grant_q) + k) % NUM_APPS);
                rr_found_c = 1'b1;
            end
        end
    end

    // The granted channel runs dry on this load unless a write lands the same edge.
    assign drain_c = fifo_one_left[grant_q] &&
                     !(send_data[grant_q] && !wr_full[grant_q]);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        load_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (rr_found_c) begin
                    grant_d = rr_pick_c;
                    beat_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                load_c = !fifo_empty[grant_q] && (!out_valid_q || out_ready);
                if (load_c) begin
                    beat_d = beat_q + BEAT_W'(1);
                    if ((beat_q == BEAT_W'(BURST - 1)) || drain_c) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end else if (fifo_empty[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output holding register: refilled on load, emptied on an unreplaced transfer.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_app_id_d = out_app_id_q;
        if (load_c) begin
            out_valid_d  = 1'b1;
            out_data_d   = head_data[grant_q];
            out_app_id_d = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(NUM_APPS - 1);
            beat_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_app_id_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_app_id_q <= out_app_id_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_app_id = out_app_id_q;

endmodule

// File: tb/tb_rah_app_arbiter.sv
// Directed self-checking bench for rah_app_arbiter at default parameters.
module tb_rah_app_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   send_data;
    logic [191:0] wr_data;
    logic [3:0]   wr_full;
    logic [3:0]   wr_almost_full;
    logic [3:0]   overflow;
    logic [3:0]   overflow_clr;
    logic         out_valid;
    logic         out_ready;
    logic [47:0]  out_data;
    logic [1:0]   out_app_id;

    int total = 0;
    int bad   = 0;

    logic [1:0]  id_q   [$];
    logic [47:0] data_q [$];

    logic [1:0]  exp_rr_id [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd1, 2'd3};
    logic [47:0] exp_rr_d  [9] = '{48'h0A0, 48'h0A1, 48'h1A0, 48'h1A1, 48'h3A0,
                                   48'h3A1, 48'h0A2, 48'h1A2, 48'h3A2};
    logic [1:0]  exp_of_id [5] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
    logic [47:0] exp_of_d  [5] = '{48'h0C, 48'h11, 48'h12, 48'h13, 48'h14};

    rah_app_arbiter #(
        .DATA_WIDTH (48),
        .NUM_APPS   (4),
        .DEPTH      (4),
        .BURST      (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .send_data      (send_data),
        .wr_data        (wr_data),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .overflow       (overflow),
        .overflow_clr   (overflow_clr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_app_id     (out_app_id)
    );

    always #5 clk = ~clk;

    // Record every beat that transfers on the coming rising edge.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            id_q.push_back(out_app_id);
            data_q.push_back(out_data);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [3:0] mask, input logic [47:0] d0, input logic [47:0] d1,
                       input logic [47:0] d2, input logic [47:0] d3);
        send_data = mask;
        wr_data   = {d3, d2, d1, d0};
        step();
        send_data    = '0;
        overflow_clr = '0;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        out_ready    = 1'b0;
        send_data    = '0;
        overflow_clr = '0;
        step();
        step();
        rstn = 1'b1;
        id_q.delete();
        data_q.delete();
    endtask

    function automatic logic [63:0] got_id(input int i);
        return (i < id_q.size()) ? 64'(id_q[i]) : 64'hDEAD;
    endfunction

    function automatic logic [63:0] got_data(input int i);
        return (i < data_q.size()) ? 64'(data_q[i]) : 64'hDEAD;
    endfunction

    initial begin
        rstn         = 1'b0;
        send_data    = '0;
        wr_data      = '0;
        overflow_clr = '0;
        out_ready    = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_app_id", 64'(out_app_id), 64'd0);
        chk("rst_wr_full", 64'(wr_full), 64'd0);
        chk("rst_wr_almost_full", 64'(wr_almost_full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        step();
        step();
        rstn = 1'b1;

        // Single write into an idle block: valid two edges after the write edge.
        out_ready = 1'b1;
        put(4'b0100, 48'h0, 48'h0, 48'hA1, 48'h0);
        chk("lat_e0_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_e1_valid", 64'(out_valid), 64'd0);
        step();
        chk("lat_e2_valid", 64'(out_valid), 64'd1);
        chk("lat_e2_data", 64'(out_data), 64'hA1);
        chk("lat_e2_id", 64'(out_app_id), 64'd2);
        repeat (4) step();

        // Round-robin bursts of two across channels 0, 1 and 3.
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            put(4'b1011, 48'h0A0 + 48'(k), 48'h1A0 + 48'(k), 48'h0, 48'h3A0 + 48'(k));
        end
        repeat (25) step();
        chk("rr_count", 64'(id_q.size()), 64'd9);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("rr_id%0d", i), got_id(i), 64'(exp_rr_id[i]));
            chk($sformatf("rr_data%0d", i), got_data(i), 64'(exp_rr_d[i]));
        end

        // Channel 0 parks a word in the output register so channel 1 fills up.
        do_reset();
        put(4'b0001, 48'h0C, 48'h0, 48'h0, 48'h0);
        repeat (2) step();
        chk("of_parked_valid", 64'(out_valid), 64'd1);
        put(4'b0010, 48'h0, 48'h11, 48'h0, 48'h0);
        put(4'b0010, 48'h0, 48'h12, 48'h0, 48'h0);
        put(4'b0010, 48'h0, 48'h13, 48'h0, 48'h0);
        chk("of_almost_full3", 64'(wr_almost_full[1]), 64'd1);
        chk("of_not_full3", 64'(wr_full[1]), 64'd0);
        put(4'b0010, 48'h0, 48'h14, 48'h0, 48'h0);
        chk("of_full4", 64'(wr_full[1]), 64'd1);
        chk("of_no_ovf_yet", 64'(overflow[1]), 64'd0);
        overflow_clr = 4'b0010;
        put(4'b0010, 48'h0, 48'h15, 48'h0, 48'h0);
        chk("of_set_wins", 64'(overflow[1]), 64'd1);
        chk("of_still_full", 64'(wr_full[1]), 64'd1);
        chk("of_hold_data", 64'(out_data), 64'h0C);
        chk("of_hold_id", 64'(out_app_id), 64'd0);
        overflow_clr = 4'b0010;
        step();
        overflow_clr = '0;
        chk("of_cleared", 64'(overflow[1]), 64'd0);
        out_ready = 1'b1;
        repeat (15) step();
        chk("of_count", 64'(id_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("of_id%0d", i), got_id(i), 64'(exp_of_id[i]));
            chk($sformatf("of_data%0d", i), got_data(i), 64'(exp_of_d[i]));
        end
        chk("of_drained_full", 64'(wr_full[1]), 64'd0);

        // Backpressure: pending beat holds for ten cycles, then moves on the first ready.
        do_reset();
        put(4'b0100, 48'h0, 48'h0, 48'hB2, 48'h0);
        put(4'b0100, 48'h0, 48'h0, 48'hB3, 48'h0);
        step();
        chk("bp_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp_hold%0d", i), {14'd0, out_app_id, out_data}, {14'd0, 2'd2, 48'hB2});
        end
        chk("bp_no_transfer", 64'(id_q.size()), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_count", 64'(data_q.size()), 64'd1);
        chk("bp_first", got_data(0), 64'hB2);
        chk("bp_next_data", 64'(out_data), 64'hB3);
        repeat (4) step();

        // Reset in the middle of a channel-2 burst.
        do_reset();
        put(4'b1100, 48'h0, 48'h0, 48'hC0, 48'hD0);
        put(4'b1100, 48'h0, 48'h0, 48'hC1, 48'hD1);
        step();
        chk("mid_valid", 64'(out_valid), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        step();
        rstn = 1'b1;
        id_q.delete();
        data_q.delete();
        out_ready = 1'b1;
        put(4'b1011, 48'hE0, 48'hE1, 48'h0, 48'hE3);
        repeat (10) step();
        chk("mid_count", 64'(id_q.size()), 64'd3);
        chk("mid_first_id", got_id(0), 64'd0);
        chk("mid_second_id", got_id(1), 64'd1);
        chk("mid_third_id", got_id(2), 64'd3);
        chk("mid_first_data", got_data(0), 64'hE0);
        chk("mid_third_data", got_data(2), 64'hE3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
